// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and keyword table for the UART command parser.
// Keywords are stored right-justified so a character is picked by its position from the left.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_START   = 3'd1,
      CMD_PAUSE   = 3'd2,
      CMD_RESUME  = 3'd3,
      CMD_RESTART = 3'd4,
      CMD_RESET   = 3'd5,
      CMD_NEXT    = 3'd6,
      CMD_STOP    = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      S_RECV    = 2'd0,
      S_PROC    = 2'd1,
      S_MATCH   = 2'd2,
      S_DISCARD = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   localparam int KW_NUM = 7;
   localparam int KW_MAX = 7;

   // Entry index equals the command code.
   localparam logic [KW_MAX*8-1:0] KW_TEXT [1:KW_NUM] = '{
      {16'h0, "start"}, {16'h0, "pause"}, {8'h0, "resume"}, "restart",
      {16'h0, "reset"}, {24'h0, "next"}, {24'h0, "stop"}
   };
   localparam int KW_LEN [1:KW_NUM] = '{5, 5, 6, 7, 5, 4, 4};

   function automatic logic [7:0] kw_char(input int code, input int pos);
      return KW_TEXT[code][(KW_LEN[code]-1-pos)*8 +: 8];
   endfunction

endpackage

// File: rtl/uart_cmd_match.sv
// Combinational keyword lookup: compares the first len buffered characters
// against every table entry of exactly that length.
module uart_cmd_match
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic [MAX_LEN*8-1:0] buf_i,
   input  logic [LW-1:0]        len_i,
   output logic                 hit_o,
   output cmd_e                 code_o
);

   logic eq;

   always_comb begin
      hit_o  = 1'b0;
      code_o = CMD_NONE;
      eq     = 1'b0;
      for (int c = 1; c <= KW_NUM; c++) begin
         eq = (KW_LEN[c] <= MAX_LEN) && (int'(len_i) == KW_LEN[c]);
         for (int p = 0; p < KW_MAX && p < MAX_LEN; p++) begin
            if (p < KW_LEN[c] && buf_i[p*8 +: 8] != kw_char(c, p)) eq = 1'b0;
         end
         if (eq && !hit_o) begin
            hit_o  = 1'b1;
            code_o = cmd_e'(3'(c));
         end
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Pops ASCII bytes from a first-word-fall-through RX FIFO, assembles '\n'-terminated
// lines and pulses a command code (or an error) once per completed line.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int MAX_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_empty,
   output logic       rx_pop,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic       cmd_err,
   output logic       busy,
   output state_e     dbg_state_o
);

   localparam int LW = $clog2(MAX_LEN + 1);

   state_e               state_q;
   logic [LW-1:0]        len_q;
   logic [MAX_LEN*8-1:0] buf_q;
   logic [7:0]           byte_q;
   logic                 valid_q;
   logic                 err_q;
   logic [2:0]           code_q;
   logic                 hit;
   cmd_e                 hit_code;

   uart_cmd_match #(.MAX_LEN(MAX_LEN)) u_match (
      .buf_i  (buf_q),
      .len_i  (len_q),
      .hit_o  (hit),
      .code_o (hit_code)
   );

   // Pops only in the two consuming states; held low while reset is asserted.
   assign rx_pop      = reset && !rx_empty && (state_q == S_RECV || state_q == S_DISCARD);
   assign busy        = (state_q != S_RECV);
   assign cmd_valid   = valid_q;
   assign cmd_err     = err_q;
   assign cmd_code    = code_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RECV;
         len_q   <= '0;
         buf_q   <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_RECV: begin
               if (!rx_empty) begin
                  byte_q  <= rx_data;
                  state_q <= S_PROC;
               end
            end
            S_PROC: begin
               if (byte_q == ASCII_LF) begin
                  state_q <= (len_q == '0) ? S_RECV : S_MATCH;
               end else if (byte_q == ASCII_CR) begin
                  state_q <= S_RECV;
               end else if (len_q < LW'(MAX_LEN)) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (len_q == LW'(i)) buf_q[i*8 +: 8] <= byte_q;
                  end
                  len_q   <= len_q + LW'(1);
                  state_q <= S_RECV;
               end else begin
                  state_q <= S_DISCARD;
               end
            end
            S_MATCH: begin
               if (hit) begin
                  valid_q <= 1'b1;
                  code_q  <= hit_code;
               end else begin
                  err_q <= 1'b1;
               end
               len_q   <= '0;
               state_q <= S_RECV;
            end
            S_DISCARD: begin
               // Drain the rest of an overlong line; its '\n' reports the error.
               if (!rx_empty && rx_data == ASCII_LF) begin
                  err_q   <= 1'b1;
                  len_q   <= '0;
                  state_q <= S_RECV;
               end
            end
            default: state_q <= S_RECV;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FIFO model, line-level reference model and cycle-exact pulse checks.
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   localparam int MAX_LEN = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_pop;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_err;
   logic       busy;
   state_e     dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   uart_cmd_parser #(.MAX_LEN(MAX_LEN)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .rx_pop      (rx_pop),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_err     (cmd_err),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // kind: 0 = no pulse, 1 = command, 2 = unknown line, 3 = overflowed line
   typedef struct { int kind; logic [2:0] code; } exp_t;
   typedef struct { int at; int kind; logic [2:0] code; } pend_t;

   logic [7:0] fifo_q[$];
   logic [7:0] line_b[$];
   exp_t       line_q[$];
   pend_t      pend_q[$];
   logic [2:0] last_code = 3'd0;
   string      kw [1:7] = '{"start", "pause", "resume", "restart", "reset", "next", "stop"};

   task automatic refresh();
      rx_empty = (fifo_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : fifo_q[0];
   endtask

   function automatic exp_t eval_line();
      exp_t e;
      e.kind = 2;
      e.code = 3'd0;
      if (line_b.size() == 0) e.kind = 0;
      else if (line_b.size() > MAX_LEN) e.kind = 3;
      else begin
         for (int c = 1; c <= 7; c++) begin
            if (kw[c].len() == line_b.size()) begin
               bit same = 1'b1;
               for (int i = 0; i < line_b.size(); i++) if (kw[c][i] != line_b[i]) same = 1'b0;
               if (same) begin e.kind = 1; e.code = 3'(c); end
            end
         end
      end
      return e;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'h0D) return;
      if (b == 8'h0A) begin
         line_q.push_back(eval_line());
         line_b.delete();
      end else line_b.push_back(b);
   endtask

   task automatic push_str(input string s, input int gap_max);
      for (int i = 0; i < s.len(); i++) begin
         fifo_q.push_back(s[i]);
         model_byte(s[i]);
         refresh();
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(fifo_q.size() == 0 && !busy && pend_q.size() == 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 400) else begin
         errors++;
         $error("FAIL idle_timeout observed=%0d cycles required<400", n);
      end
      repeat (2) @(negedge clk);
   endtask

   // FIFO side: pop on a strobe seen at the edge, update the read port just after it.
   always @(posedge clk) begin
      int c;
      logic [7:0] b;
      exp_t e;
      pend_t p;
      c = cyc;
      cyc = cyc + 1;
      if (rx_pop) begin
         checks++;
         assert (fifo_q.size() > 0) else begin
            errors++;
            $error("FAIL pop_when_empty observed=pop required=no_pop cycle=%0d", c);
         end
         if (fifo_q.size() > 0) begin
            b = fifo_q[0];
            if (b == 8'h0A) begin
               checks++;
               assert (line_q.size() > 0) else begin
                  errors++;
                  $error("FAIL lf_unexpected observed=lf_pop required=no_line cycle=%0d", c);
               end
               if (line_q.size() > 0) begin
                  e = line_q.pop_front();
                  if (e.kind != 0) begin
                     p.at   = c + ((e.kind == 3) ? 1 : 3);
                     p.kind = e.kind;
                     p.code = e.code;
                     pend_q.push_back(p);
                  end
               end
            end
            #1;
            void'(fifo_q.pop_front());
            refresh();
         end
      end
   end

   // Output monitor: every cycle out of reset, pulses must match the schedule exactly.
   always @(negedge clk) begin
      logic ev, ee;
      pend_t p;
      if (reset) begin
         ev = 1'b0;
         ee = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].at == cyc) begin
            p = pend_q.pop_front();
            ev = (p.kind == 1);
            ee = (p.kind >= 2);
            if (ev) last_code = p.code;
         end
         checks++;
         assert (cmd_valid === ev) else begin
            errors++;
            $error("FAIL cmd_valid cycle=%0d observed=%b required=%b", cyc, cmd_valid, ev);
         end
         checks++;
         assert (cmd_err === ee) else begin
            errors++;
            $error("FAIL cmd_err cycle=%0d observed=%b required=%b", cyc, cmd_err, ee);
         end
         checks++;
         assert (cmd_code === last_code) else begin
            errors++;
            $error("FAIL cmd_code cycle=%0d observed=%0d required=%0d", cyc, cmd_code, last_code);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      checks++;
      assert ({rx_pop, cmd_valid, cmd_err, cmd_code, busy} === 7'b0) else begin
         errors++;
         $error("FAIL %s observed=pop%b val%b err%b code%0d busy%b required=all_zero",
                tag, rx_pop, cmd_valid, cmd_err, cmd_code, busy);
      end
   endtask

   initial begin
      reset = 1'b0;
      refresh();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      reset = 1'b1;
      @(negedge clk);

      push_str("start\n", 0);              wait_idle();
      push_str("pause\r\n", 0);
      push_str("resume\n", 0);             wait_idle();
      push_str("jump\n", 0);               wait_idle();
      push_str("abcdefghijk\n", 3);
      push_str("stop\n", 0);               wait_idle();
      push_str("\n", 0);                   wait_idle();
      checks++;
      assert (busy === 1'b0) else begin
         errors++;
         $error("FAIL busy_after_empty_line observed=%b required=0", busy);
      end
      push_str("restart\n", 1);            wait_idle();
      push_str("abcdefgh\n", 0);           wait_idle();
      push_str("abcdefghi\n", 0);          wait_idle();
      push_str("sta\rrt\n", 2);            wait_idle();
      push_str("next\r\r\nreset\n", 0);    wait_idle();

      push_str("rest", 0);                 wait_idle();
      reset = 1'b0;
      line_b.delete();
      last_code = 3'd0;
      @(negedge clk); check_reset_outputs("mid_line_reset_1");
      @(negedge clk); check_reset_outputs("mid_line_reset_2");
      reset = 1'b1;
      push_str("art\n", 0);                wait_idle();

      for (int n = 0; n < 40; n++) begin
         string s;
         int r;
         r = $urandom_range(0, 9);
         s = "";
         if (r < 7) begin
            string k;
            k = kw[r + 1];
            for (int i = 0; i < k.len(); i++) begin
               if ($urandom_range(0, 7) == 0) s = {s, "\r"};
               s = {s, k.substr(i, i)};
            end
         end else begin
            int l;
            string abc;
            abc = "abcdefghijklmnopqrstuvwxyz";
            l = $urandom_range(0, 12);
            for (int i = 0; i < l; i++) begin
               int j;
               j = $urandom_range(0, 25);
               s = {s, abc.substr(j, j)};
            end
         end
         s = {s, "\n"};
         push_str(s, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART controller's RX FIFO, in the same PL design as the UART sender.
- Pops received ASCII bytes one at a time and assembles them into a line terminated by '\n'.
- Matches the line against a fixed keyword table and emits a one-cycle command pulse with a 3-bit code to the game-state logic.
- Overlong or unknown lines produce a one-cycle error pulse instead.

Parameters:
- MAX_LEN, 8, maximum stored characters per line, excluding the terminator.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0); one clock domain only
- rx_data  in  8  RX FIFO read data; first-word-fall-through, valid whenever rx_empty=0
- rx_empty  in  1  RX FIFO empty flag
- rx_pop  out  1  one-cycle pop strobe to the RX FIFO
- cmd_valid  out  1  one-cycle pulse: cmd_code is a newly decoded command
- cmd_code  out  3  decoded command; holds its last value between pulses
- cmd_err  out  1  one-cycle pulse: line unknown or overflowed
- busy  out  1  high in every state except S_RECV

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_RECV, len=0, char buffer cleared.
  - rx_pop=0, cmd_valid=0, cmd_code=0, cmd_err=0.
  - A reset mid-line discards the partial line; no pulse is emitted after release.
- Command table (case-sensitive, exact length match):
  - "start"=1, "pause"=2, "resume"=3, "restart"=4, "reset"=5, "next"=6, "stop"=7.
  - Code 0 is reserved (never pulsed).
- Character handling:
  - '\r' (0x0D) is ignored everywhere.
  - '\n' (0x0A) terminates a line.
- States:
  - S_RECV: if rx_empty=0, assert rx_pop for this cycle, latch rx_data into byte_reg, go to S_PROC. Otherwise stay; rx_pop=0.
  - S_PROC:
    - byte=='\n' and len==0 -> S_RECV, no pulse (empty line).
    - byte=='\n' and len>0 -> S_MATCH.
    - byte=='\r' -> S_RECV.
    - len<MAX_LEN -> buf[len]=byte, len++, -> S_RECV.
    - else (overflow) -> S_DISCARD.
  - S_MATCH: compare buf[0..len-1] against the table in one cycle.
    - Hit: register cmd_valid=1 and cmd_code=<code> for the next cycle.
    - Miss: register cmd_err=1 for the next cycle.
    - In both cases len=0 and next state is S_RECV.
  - S_DISCARD: pop bytes whenever rx_empty=0, one pop per cycle, dropping them.
    - On a popped '\n': register cmd_err=1 for the next cycle, len=0, -> S_RECV.
- Pop rate and timing:
  - At most one pop per two cycles outside S_DISCARD.
  - rx_pop is never asserted while rx_empty=1.
  - rx_pop is combinational from state and rx_empty.
- Latency: a '\n' popped in cycle N gives PROC at N+1, MATCH at N+2, and cmd_valid or cmd_err high during N+3 only.
- Outputs:
  - cmd_valid and cmd_err are registered, never high together, and never high for two consecutive cycles from the same line.
- Width rules:
  - len width is $clog2(MAX_LEN+1).
  - Entries shorter than MAX_LEN compare only their own length, and len must equal the keyword length.
  - Buffer contents beyond len are don't-care.
- Back-to-back lines: the first byte of the next line may be popped in cycle N+3 (the S_RECV entry cycle).

Decomposition:
- Package uart_cmd_pkg:
  - cmd_e enum (CMD_NONE=0 ... CMD_STOP=7).
  - ASCII constants ASCII_LF and ASCII_CR.
  - state_e (S_RECV, S_PROC, S_MATCH, S_DISCARD).
  - Keyword strings with their lengths.
- Sub-module uart_cmd_match (purely combinational):
  - Inputs: buffer and len.
  - Outputs: hit and code.
  - The parser FSM instantiates it once.

Test Plan:
- Push "start\n" into the FIFO model -> exactly one cmd_valid pulse, cmd_code=1, three cycles after the '\n' pop; cmd_err stays 0.
- Push "pause\r\n" then "resume\n" back-to-back -> cmd_code=2 pulse, then a cmd_code=3 pulse; the '\r' is ignored; no cmd_err.
- Push "jump\n" -> one cmd_err pulse; cmd_valid=0; cmd_code keeps its previous value.
- Push "abcdefghijk\n" (11 chars, MAX_LEN=8), then "stop\n":
  - One cmd_err pulse after the first '\n', with no pop while the FIFO is empty.
  - Then cmd_code=7.
- Push "\n" alone -> no pulse on any output; busy returns to 0.
- Push "rest" without '\n', assert reset=0 for 2 cycles, release, then push "art\n":
  - All outputs read 0 during reset.
  - The completed line "art" gives one cmd_err pulse (no merging across reset).
